// File: rtl/lut_sched_pkg.sv
// Shared types and default dimensions for the time-multiplexed LogicNets layer sequencer.
package lut_sched_pkg;

    localparam int unsigned NEURONS = 16;
    localparam int unsigned IN_W    = 6;
    localparam int unsigned OUT_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // ROM address is {neuron index, fan-in code}
    function automatic int unsigned calc_addr_w(input int unsigned neurons, input int unsigned in_w);
        return $clog2(neurons) + in_w;
    endfunction

endpackage

// File: rtl/lut_layer_sched.sv
// Evaluates one layer of truth-table neurons by issuing one lookup per neuron
// through a single shared synchronous ROM port, assembling the activations.
module lut_layer_sched #(
    parameter  int unsigned NEURONS = lut_sched_pkg::NEURONS,
    parameter  int unsigned IN_W    = lut_sched_pkg::IN_W,
    parameter  int unsigned OUT_W   = lut_sched_pkg::OUT_W,
    localparam int unsigned IDX_W   = $clog2(NEURONS),
    localparam int unsigned ADDR_W  = lut_sched_pkg::calc_addr_w(NEURONS, IN_W)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NEURONS*IN_W-1:0]    in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NEURONS*OUT_W-1:0]   out_data,
    output logic                       rom_req,
    input  logic                       rom_gnt,
    output logic [ADDR_W-1:0]          rom_addr,
    input  logic [OUT_W-1:0]           rom_rdata,
    output logic [15:0]                vec_count
);

    lut_sched_pkg::state_e r_state;

    logic [NEURONS*IN_W-1:0]  r_in_reg;
    logic [IDX_W-1:0]         r_idx;
    logic [IDX_W-1:0]         r_pidx;
    logic                     r_pend;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic                     r_rom_req;
    logic [ADDR_W-1:0]        r_rom_addr;
    logic [NEURONS*OUT_W-1:0] r_out_data;
    logic [15:0]              r_vec_count;

    logic                     w_grant;
    logic                     w_last;
    logic [IDX_W-1:0]         w_next_idx;
    logic [IN_W-1:0]          w_next_code;

    assign w_grant     = r_rom_req & rom_gnt;
    assign w_last      = (r_idx == IDX_W'(NEURONS - 1));
    assign w_next_idx  = r_idx + IDX_W'(1);
    assign w_next_code = r_in_reg[w_next_idx*IN_W +: IN_W];

    // Sequencer: request per neuron, capture data one cycle after each grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= lut_sched_pkg::ST_IDLE;
            r_in_reg    <= '0;
            r_idx       <= '0;
            r_pidx      <= '0;
            r_pend      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_rom_req   <= 1'b0;
            r_rom_addr  <= '0;
            r_out_data  <= '0;
            r_vec_count <= '0;
        end else begin
            r_pend <= 1'b0;
            if (r_pend) begin
                r_out_data[r_pidx*OUT_W +: OUT_W] <= rom_rdata;
            end

            case (r_state)
                lut_sched_pkg::ST_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_in_reg   <= in_data;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_rom_req  <= 1'b1;
                        r_rom_addr <= {IDX_W'(0), in_data[IN_W-1:0]};
                        r_state    <= lut_sched_pkg::ST_ISSUE;
                    end
                end

                lut_sched_pkg::ST_ISSUE: begin
                    if (w_grant) begin
                        r_pend <= 1'b1;
                        r_pidx <= r_idx;
                        if (w_last) begin
                            r_rom_req <= 1'b0;
                        end else begin
                            r_idx      <= w_next_idx;
                            r_rom_addr <= {w_next_idx, w_next_code};
                        end
                    end else if (!r_rom_req && r_pend) begin
                        // last activation lands this edge
                        r_out_valid <= 1'b1;
                        r_state     <= lut_sched_pkg::ST_DONE;
                    end
                end

                lut_sched_pkg::ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_vec_count <= r_vec_count + 16'd1;
                        r_in_ready  <= 1'b1;
                        r_state     <= lut_sched_pkg::ST_IDLE;
                    end
                end

                default: r_state <= lut_sched_pkg::ST_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign rom_req   = r_rom_req;
    assign rom_addr  = r_rom_addr;
    assign vec_count = r_vec_count;

endmodule

// File: tb/tb_lut_layer_sched.sv
// Scoreboard bench for lut_layer_sched: behavioural ROM, grant generator and table-driven reference.
module tb_lut_layer_sched;

    localparam int unsigned N     = lut_sched_pkg::NEURONS;
    localparam int unsigned IN_W  = lut_sched_pkg::IN_W;
    localparam int unsigned OUT_W = lut_sched_pkg::OUT_W;
    localparam int unsigned AW    = lut_sched_pkg::calc_addr_w(N, IN_W);

    logic                   clk;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [N*IN_W-1:0]      in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [N*OUT_W-1:0]     out_data;
    logic                   rom_req;
    logic                   rom_gnt;
    logic [AW-1:0]          rom_addr;
    logic [OUT_W-1:0]       rom_rdata;
    logic [15:0]            vec_count;

    lut_layer_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rom_req   (rom_req),
        .rom_gnt   (rom_gnt),
        .rom_addr  (rom_addr),
        .rom_rdata (rom_rdata),
        .vec_count (vec_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int stalls = 0;
    int grants = 0;
    int gnt_mode = 0;

    logic [OUT_W-1:0]   rom_tbl [0:(1<<AW)-1];
    logic [N*OUT_W-1:0] exp_out_q  [$];
    logic [AW-1:0]      exp_addr_q [$];
    logic [15:0]        model_cnt = 16'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One-cycle synchronous ROM; unrequested cycles return junk that must be ignored
    always @(posedge clk) begin
        if (rom_req && rom_gnt) rom_rdata <= rom_tbl[rom_addr];
        else                    rom_rdata <= 2'b11;
    end

    always @(negedge clk) begin
        case (gnt_mode)
            0:       rom_gnt = 1'b1;
            1:       rom_gnt = (cyc % 2 == 0);
            default: rom_gnt = ($urandom_range(0, 3) != 0);
        endcase
    end

    function automatic logic [N*OUT_W-1:0] expect_vec(input logic [N*IN_W-1:0] d);
        logic [N*OUT_W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++)
            r[k*OUT_W +: OUT_W] = rom_tbl[k*(1<<IN_W) + int'(d[k*IN_W +: IN_W])];
        return r;
    endfunction

    // Monitor: lookup order, stall stability, result scoreboard, completion counter
    logic          p_req = 1'b0;
    logic          p_gnt = 1'b0;
    logic [AW-1:0] p_addr = '0;
    bit            cnt_due = 1'b0;
    always begin
        logic [AW-1:0]      ea;
        logic [N*OUT_W-1:0] eo;
        @(negedge clk);
        #1;
        if (!rst_n) begin
            p_req   = 1'b0;
            cnt_due = 1'b0;
        end else begin
            if (cnt_due) begin
                chk(vec_count == model_cnt, "vec_count", 64'(vec_count), 64'(model_cnt));
                chk(in_ready == 1'b1, "in_ready_after_done", 64'(in_ready), 64'd1);
                cnt_due = 1'b0;
            end
            if (p_req && !p_gnt) begin
                stalls++;
                chk(rom_req && rom_addr == p_addr, "addr_stable", 64'(rom_addr), 64'(p_addr));
            end
            if (p_req && p_gnt) begin
                grants++;
                if (exp_addr_q.size() == 0) begin
                    chk(1'b0, "unexpected_lookup", 64'(p_addr), 64'd0);
                end else begin
                    ea = exp_addr_q.pop_front();
                    chk(p_addr == ea, "lookup_order", 64'(p_addr), 64'(ea));
                end
            end
            p_req  = rom_req;
            p_gnt  = rom_gnt;
            p_addr = rom_addr;
            if (out_valid && out_ready) begin
                if (exp_out_q.size() == 0) begin
                    chk(1'b0, "unexpected_result", 64'(out_data), 64'd0);
                end else begin
                    eo = exp_out_q.pop_front();
                    chk(out_data == eo, "out_data", 64'(out_data), 64'(eo));
                end
                model_cnt = model_cnt + 16'd1;
                cnt_due   = 1'b1;
            end
        end
    end

    task automatic issue_vec(input logic [N*IN_W-1:0] d, output int t0);
        int budget;
        budget = 0;
        t0 = 0;
        @(negedge clk);
        while (!in_ready && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            chk(1'b0, "in_ready_timeout", 64'd0, 64'd1);
            return;
        end
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b0;
        exp_out_q.push_back(expect_vec(d));
        for (int k = 0; k < N; k++)
            exp_addr_q.push_back(AW'(k*(1<<IN_W) + int'(d[k*IN_W +: IN_W])));
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom};
        t0       = cyc;
        stalls   = 0;
        grants   = 0;
        chk(!in_ready && rom_req, "accept", 64'({in_ready, rom_req}), 64'b01);
    endtask

    task automatic run_vec(input logic [N*IN_W-1:0] d, input int hold);
        int t0;
        int budget;
        logic [N*OUT_W-1:0] held;
        issue_vec(d, t0);
        budget = 0;
        while (!out_valid && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!out_valid) begin
            chk(1'b0, "out_valid_timeout", 64'd0, 64'd1);
            return;
        end
        chk(cyc - t0 == int'(N) + 1 + stalls, "latency", 64'(cyc - t0), 64'(int'(N) + 1 + stalls));
        held = out_data;
        for (int i = 0; i < hold; i++) begin
            chk(out_valid && out_data == held, "bp_hold", 64'(out_data), 64'(held));
            chk(!in_ready && !rom_req, "bp_quiet", 64'({in_ready, rom_req}), 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [N*IN_W-1:0] all3f;
        logic [N*IN_W-1:0] d;
        int t0;
        int budget;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; gnt_mode = 0;
        for (int a = 0; a < (1 << AW); a++)
            rom_tbl[a] = OUT_W'(((a >> IN_W) + (a % (1 << IN_W))) % 4);
        all3f = '1;
        repeat (3) @(negedge clk);
        chk({in_ready, out_valid, rom_req} == 3'b000, "reset_ctrl", 64'({in_ready, out_valid, rom_req}), 64'd0);
        chk(rom_addr == '0 && out_data == '0 && vec_count == 16'd0, "reset_data",
            64'({rom_addr, out_data}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk(in_ready == 1'b1, "ready_after_reset", 64'(in_ready), 64'd1);

        // Ideal back-to-back, then grant stalls, then output backpressure
        run_vec(all3f, 0);
        run_vec(all3f, 0);
        gnt_mode = 1;
        run_vec(all3f, 0);
        gnt_mode = 0;
        d = {$urandom, $urandom, $urandom};
        run_vec(d, 10);

        // Reset while idx = 7
        issue_vec({$urandom, $urandom, $urandom}, t0);
        budget = 0;
        while (grants < 7 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        rst_n = 1'b0;
        exp_out_q.delete();
        exp_addr_q.delete();
        model_cnt = 16'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk({in_ready, out_valid, rom_req} == 3'b000 && rom_addr == '0, "mid_reset_ctrl",
                64'({in_ready, out_valid, rom_req, rom_addr}), 64'd0);
            chk(out_data == '0 && vec_count == 16'd0, "mid_reset_data", 64'({vec_count, out_data}), 64'd0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk(in_ready == 1'b1, "ready_after_mid_reset", 64'(in_ready), 64'd1);
        run_vec({$urandom, $urandom, $urandom}, 2);

        // Counter wrap
        @(negedge clk);
        force dut.r_vec_count = 16'hFFFF;
        #1;
        release dut.r_vec_count;
        model_cnt = 16'hFFFF;
        #1;
        chk(vec_count == 16'hFFFF, "preload", 64'(vec_count), 64'hFFFF);
        run_vec({$urandom, $urandom, $urandom}, 0);

        // Randomised table, codes, grants and backpressure
        for (int a = 0; a < (1 << AW); a++)
            rom_tbl[a] = OUT_W'($urandom);
        gnt_mode = 2;
        for (int v = 0; v < 20; v++)
            run_vec({$urandom, $urandom, $urandom}, $urandom_range(0, 3));

        repeat (3) @(negedge clk);
        chk(exp_out_q.size() == 0, "results_drained", 64'(exp_out_q.size()), 64'd0);
        chk(exp_addr_q.size() == 0, "lookups_drained", 64'(exp_addr_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
